mem_arbiter: RTL

Multi-core access arbiter sitting directly upstream of the shared data RAM. Accepts independent read/write requests from `NUM_CORES` processor cores, grants one per cycle, and drives the RAM's single write-enable/address/data port. Routes the RAM's read data back to the issuing core one cycle later, with a per-core valid strobe.

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/mem_arbiter.sv | 47 ++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: default sizes and shared types for the multi-core RAM arbiter
package mem_arb_pkg;
  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_WIDTH = 12;
  localparam int DEF_DEPTH = 256;
  typedef logic [DEF_NUM_CORES-1:0] core_onehot_t;
  typedef logic [$clog2(DEF_NUM_CORES)-1:0] core_idx_t;
  typedef logic [$clog2(DEF_DEPTH)-1:0] mem_addr_t;
  typedef logic [DEF_WIDTH-1:0] mem_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant picker; round-robin when MEM_ARB_ROUND_ROBIN_EN is defined, else fixed priority (core 0 highest)
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = DEF_NUM_CORES,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] c;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_gnt;
  // remember the most recent winner so the search starts just after it
  always_ff @(posedge clk)
    if (!rstN) last_gnt <= IW'(N - 1);
    else if (|gnt) last_gnt <= idx;
  // scan from last_gnt+N down to last_gnt+1 so the nearest requester after last_gnt wins
  always_comb begin
    c = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      c = IW'((int'(last_gnt) + k) % N);
      if (req[c]) idx = c;
    end
    gnt = (rstN && |req) ? N'(1) << idx : '0;
  end
`else
  logic unused_clk;
  assign unused_clk = clk;
  // lowest requesting index wins
  always_comb begin
    c = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = IW'(k);
      if (req[c]) idx = c;
    end
    gnt = (rstN && |req) ? N'(1) << idx : '0;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one core per cycle onto the shared RAM port and returns read data one cycle later (MEM_ARB_ROUND_ROBIN_EN selects round-robin)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rstN,
  input  logic [NUM_CORES-1:0]                 core_req,
  input  logic [NUM_CORES-1:0]                 core_wrEn,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES-1:0][WIDTH-1:0]      core_dataIn,
  output logic [NUM_CORES-1:0]                 core_gnt,
  output logic [NUM_CORES-1:0]                 core_rdValid,
  output logic [WIDTH-1:0]                     core_dataOut,
  output logic                                 mem_wrEn,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [WIDTH-1:0]                     mem_dataIn,
  input  logic [WIDTH-1:0]                     mem_dataOut
);
  localparam int IW = $clog2(NUM_CORES);
  logic [IW-1:0] gnt_idx;
  logic [NUM_CORES-1:0] rd_owner;
  logic any_gnt;
  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk (clk),
    .rstN(rstN),
    .req (core_req),
    .gnt (core_gnt),
    .idx (gnt_idx)
  );
  // steer the winner onto the RAM port and gate the read return
  always_comb begin
    any_gnt = |core_gnt;
    mem_wrEn = any_gnt & core_wrEn[gnt_idx];
    mem_addr = any_gnt ? core_addr[gnt_idx] : '0;
    mem_dataIn = any_gnt ? core_dataIn[gnt_idx] : '0;
    core_rdValid = rstN ? rd_owner : '0;
    core_dataOut = |core_rdValid ? mem_dataOut : '0;
  end
  // the granted reader owns the RAM output on the following cycle
  always_ff @(posedge clk)
    rd_owner <= !rstN ? '0 : core_gnt & ~core_wrEn;
endmodule
